// File: rtl/spi_axis_pkg.sv
// Shared types and constants for the SPI <-> AXI-Stream bridge.
//   tx_load_state_e : states of the SPI transmit load sequencer
//   rx_entry_t      : RX FIFO entry {last, data} at the default 8-bit word width
//   DATA_FILL       : value driven on data outputs when nothing is valid
//   CS_N_IDLE       : chip-select level assumed while in reset
//   OVF_COUNT_MAX   : saturation point of the dropped-word counter
package spi_axis_pkg;

  typedef enum logic [1:0] {
    TX_IDLE      = 2'd0,
    TX_LOAD      = 2'd1,
    TX_WAIT_BUSY = 2'd2,
    TX_WAIT_DONE = 2'd3
  } tx_load_state_e;

  localparam int         DEFAULT_DATA_WIDTH = 8;
  localparam logic       DATA_FILL          = 1'b0;
  localparam logic       CS_N_IDLE          = 1'b1;
  localparam logic [7:0] OVF_COUNT_MAX      = 8'hFF;

  typedef struct packed {
    logic                          last;
    logic [DEFAULT_DATA_WIDTH-1:0] data;
  } rx_entry_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == OVF_COUNT_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/spi_axis_sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
//   push/push_data : write when push=1 and not full (or full with a same-cycle pop)
//   pop/pop_data   : pop_data always shows the head; pop=1 advances when not empty
//   flush          : empties the FIFO; a same-cycle push is discarded
//   full/empty     : occupancy flags
//   level          : current number of entries (0..DEPTH)
module spi_axis_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  input  logic                     flush,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign level   = wr_ptr - rd_ptr;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/spi_axis_bridge_fifo.sv
// SPI slave PHY <-> axis_wb_master bridge with RX and TX buffering.
//   spi_rx_*      : words received by the SPI shifter, buffered toward m_axis_*
//   s_axis_*      : responses, buffered toward the SPI shifter via spi_tx_*
//   spi_busy      : shifter is mid-word; spi_cs_n frames transfers
//   rx/tx_level   : FIFO occupancies
//   rx_overflow, tx_underrun, ovf_count : sticky status, cleared by status_clr
//
// TX load sequencer:
//   state        | meaning
//   TX_IDLE      | waiting for cs_n low, shifter idle and a queued word
//   TX_LOAD      | spi_tx_valid high for one cycle with the head word; pop it
//   TX_WAIT_BUSY | word handed over, waiting for the shifter to start
//   TX_WAIT_DONE | shifter running, waiting for it to finish
//   cs_n high returns the sequencer to TX_IDLE from any state.
module spi_axis_bridge_fifo
  import spi_axis_pkg::*;
#(
  parameter int DATA_WIDTH       = 8,
  parameter int RX_DEPTH         = 16,
  parameter int TX_DEPTH         = 16,
  parameter int EXPLICIT_FRAMING = 0,
  parameter int FLUSH_TX_ON_CS   = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_WIDTH-1:0]       spi_rx_data,
  input  logic                        spi_rx_valid,
  output logic [DATA_WIDTH-1:0]       spi_tx_data,
  output logic                        spi_tx_valid,
  input  logic                        spi_busy,
  input  logic                        spi_cs_n,
  output logic [DATA_WIDTH-1:0]       m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tlast,
  input  logic [DATA_WIDTH-1:0]       s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  input  logic                        s_axis_tlast,
  output logic [$clog2(RX_DEPTH):0]   rx_level,
  output logic [$clog2(TX_DEPTH):0]   tx_level,
  output logic                        rx_overflow,
  output logic                        tx_underrun,
  output logic [7:0]                  ovf_count,
  input  logic                        status_clr
);

  localparam int RXW = DATA_WIDTH + 1;

  tx_load_state_e          state;
  logic                    cs_n_d;
  logic                    busy_d;
  logic                    cs_rise;
  logic                    busy_rise;
  logic                    ready_en;

  logic                    hold_valid;
  logic [DATA_WIDTH-1:0]   hold_data;
  logic                    tail_pending;

  logic                    rx_push;
  logic [RXW-1:0]          rx_push_data;
  logic                    rx_pop;
  logic [RXW-1:0]          rx_head;
  logic                    rx_full;
  logic                    rx_empty;
  logic                    rx_drop;

  logic                    tx_push;
  logic                    tx_pop;
  logic                    tx_flush;
  logic [DATA_WIDTH-1:0]   tx_head;
  logic                    tx_full;
  logic                    tx_empty;

  // Response-stream frame markers have no meaning on the SPI side.
  logic                    unused_tlast;
  assign unused_tlast = s_axis_tlast;

  assign cs_rise   = !cs_n_d && spi_cs_n;
  assign busy_rise = !busy_d && spi_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_n_d   <= CS_N_IDLE;
      busy_d   <= 1'b0;
      ready_en <= 1'b0;
    end else begin
      cs_n_d   <= spi_cs_n;
      busy_d   <= spi_busy;
      ready_en <= 1'b1;
    end
  end

  // With framing, the newest word waits in the hold register until we know
  // whether it is the frame tail (cs_n rise) or not (another word arrives).
  always_comb begin
    rx_push      = 1'b0;
    rx_push_data = {1'b0, spi_rx_data};
    if (EXPLICIT_FRAMING != 0) begin
      rx_push      = hold_valid && (spi_rx_valid || cs_rise || tail_pending);
      rx_push_data = {tail_pending || (cs_rise && !spi_rx_valid), hold_data};
    end else begin
      rx_push = spi_rx_valid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid   <= 1'b0;
      hold_data    <= '0;
      tail_pending <= 1'b0;
    end else if (EXPLICIT_FRAMING != 0) begin
      if (spi_rx_valid) begin
        hold_valid   <= 1'b1;
        hold_data    <= spi_rx_data;
        // A word arriving on the cs_n rise is the tail; flush it next cycle.
        tail_pending <= cs_rise;
      end else if (hold_valid && (cs_rise || tail_pending)) begin
        hold_valid   <= 1'b0;
        tail_pending <= 1'b0;
      end
    end
  end

  assign rx_pop  = !rx_empty && m_axis_tready;
  assign rx_drop = rx_push && rx_full && !rx_pop;

  spi_axis_sync_fifo #(
    .WIDTH (RXW),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_push),
    .push_data (rx_push_data),
    .pop       (rx_pop),
    .pop_data  (rx_head),
    .flush     (1'b0),
    .full      (rx_full),
    .empty     (rx_empty),
    .level     (rx_level)
  );

  assign m_axis_tvalid = !rx_empty;
  assign m_axis_tdata  = rx_empty ? {DATA_WIDTH{DATA_FILL}} : rx_head[DATA_WIDTH-1:0];
  assign m_axis_tlast  = (EXPLICIT_FRAMING != 0) && !rx_empty && rx_head[DATA_WIDTH];

  assign s_axis_tready = ready_en && !tx_full;
  assign tx_push       = s_axis_tvalid && s_axis_tready;
  assign tx_flush      = (FLUSH_TX_ON_CS != 0) && cs_rise;
  assign tx_pop        = (state == TX_LOAD);

  spi_axis_sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tx_push),
    .push_data (s_axis_tdata),
    .pop       (tx_pop),
    .pop_data  (tx_head),
    .flush     (tx_flush),
    .full      (tx_full),
    .empty     (tx_empty),
    .level     (tx_level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= TX_IDLE;
      spi_tx_valid <= 1'b0;
      spi_tx_data  <= '0;
    end else begin
      spi_tx_valid <= 1'b0;
      if (spi_cs_n) begin
        state <= TX_IDLE;
      end else begin
        case (state)
          TX_IDLE: begin
            if (!spi_busy && !tx_empty) begin
              state        <= TX_LOAD;
              spi_tx_valid <= 1'b1;
              spi_tx_data  <= tx_head;
            end
          end
          TX_LOAD:      state <= TX_WAIT_BUSY;
          TX_WAIT_BUSY: if (spi_busy)  state <= TX_WAIT_DONE;
          TX_WAIT_DONE: if (!spi_busy) state <= TX_IDLE;
          default:      state <= TX_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_overflow <= 1'b0;
      tx_underrun <= 1'b0;
      ovf_count   <= '0;
    end else if (status_clr) begin
      rx_overflow <= 1'b0;
      tx_underrun <= 1'b0;
      ovf_count   <= '0;
    end else begin
      if (rx_drop) begin
        rx_overflow <= 1'b1;
        ovf_count   <= sat_inc8(ovf_count);
      end
      // Shifter started a word with nothing queued for it.
      if (busy_rise && (state == TX_IDLE) && !spi_cs_n && tx_empty)
        tx_underrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spi_axis_bridge_fifo.sv
module tb_spi_axis_bridge_fifo;
  import spi_axis_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] spi_rx_data;
  logic       spi_rx_valid;
  logic [7:0] spi_tx_data;
  logic       spi_tx_valid;
  logic       spi_busy;
  logic       spi_cs_n;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready;
  logic       m_axis_tlast;
  logic [7:0] s_axis_tdata;
  logic       s_axis_tvalid;
  logic       s_axis_tready;
  logic       s_axis_tlast;
  logic [2:0] rx_level;
  logic [4:0] tx_level;
  logic       rx_overflow;
  logic       tx_underrun;
  logic [7:0] ovf_count;
  logic       status_clr;

  spi_axis_bridge_fifo #(
    .DATA_WIDTH       (8),
    .RX_DEPTH         (4),
    .TX_DEPTH         (16),
    .EXPLICIT_FRAMING (1),
    .FLUSH_TX_ON_CS   (1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .spi_rx_data   (spi_rx_data),
    .spi_rx_valid  (spi_rx_valid),
    .spi_tx_data   (spi_tx_data),
    .spi_tx_valid  (spi_tx_valid),
    .spi_busy      (spi_busy),
    .spi_cs_n      (spi_cs_n),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .rx_level      (rx_level),
    .tx_level      (tx_level),
    .rx_overflow   (rx_overflow),
    .tx_underrun   (tx_underrun),
    .ovf_count     (ovf_count),
    .status_clr    (status_clr)
  );

  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  int         tx_seen = 0;
  int         base;
  rx_entry_t  rx_exp[$];
  logic [7:0] tx_exp[$];
  rx_entry_t  rx_e;
  logic [7:0] tx_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rx_word(input logic [7:0] d);
    spi_rx_valid = 1'b1;
    spi_rx_data  = d;
    tick();
    spi_rx_valid = 1'b0;
  endtask

  task automatic tx_word(input logic [7:0] d);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    tick();
    s_axis_tvalid = 1'b0;
  endtask

  task automatic exp_rx(input logic l, input logic [7:0] d);
    rx_exp.push_back({l, d});
  endtask

  task automatic wait_tx(input int target, input string name);
    for (int i = 0; i < 60 && tx_seen < target; i++) tick();
    check(name, tx_seen, target);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_tvalid"},   m_axis_tvalid, 0);
    check({tag, "_tdata"},    m_axis_tdata,  0);
    check({tag, "_tlast"},    m_axis_tlast,  0);
    check({tag, "_tready"},   s_axis_tready, 0);
    check({tag, "_txvalid"},  spi_tx_valid,  0);
    check({tag, "_txdata"},   spi_tx_data,   0);
    check({tag, "_rx_level"}, rx_level,      0);
    check({tag, "_tx_level"}, tx_level,      0);
    check({tag, "_ovf"},      rx_overflow,   0);
    check({tag, "_unr"},      tx_underrun,   0);
    check({tag, "_ovfcnt"},   ovf_count,     0);
  endtask

  // Scoreboard monitor: compares every accepted AXIS beat and every SPI load.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_axis_tvalid && m_axis_tready) begin
        if (rx_exp.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected_beat: got data %0h last %0b, required no beat", m_axis_tdata, m_axis_tlast);
        end else begin
          rx_e = rx_exp.pop_front();
          check("rx_beat_data", m_axis_tdata, rx_e.data);
          check("rx_beat_last", m_axis_tlast, rx_e.last);
        end
      end
      if (spi_tx_valid) begin
        tx_seen++;
        if (tx_exp.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected_load: got data %0h, required no load", spi_tx_data);
        end else begin
          tx_e = tx_exp.pop_front();
          check("tx_load_data", spi_tx_data, tx_e);
          check("tx_load_while_idle", spi_busy, 0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    spi_rx_data = '0; spi_rx_valid = 1'b0; spi_busy = 1'b0; spi_cs_n = 1'b1;
    m_axis_tready = 1'b0; s_axis_tdata = '0; s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0; status_clr = 1'b0;
    #2;
    check_reset_values("por");
    tick(2);
    rst = 1'b0;
    tick();
    check("tready_after_release", s_axis_tready, 1);

    // Mid-frame reset with both FIFOs loaded.
    for (int i = 0; i < 5; i++) tx_word(8'h40 + 8'(i));
    for (int i = 0; i < 4; i++) rx_word(8'h20 + 8'(i));
    check("pre_reset_tx_level", tx_level, 5);
    check("pre_reset_rx_level", rx_level, 3);
    rst = 1'b1;
    #2;
    check_reset_values("midrst");
    tick();
    rst = 1'b0;
    spi_cs_n = 1'b0;
    tick(4);
    check("post_reset_rx_level", rx_level, 0);
    check("post_reset_tx_level", tx_level, 0);
    spi_cs_n = 1'b1;
    tick();

    // Framed RX: tail marked by cs_n rise.
    m_axis_tready = 1'b1;
    spi_cs_n = 1'b0;
    tick();
    exp_rx(0, 8'hA1); exp_rx(0, 8'h00); exp_rx(0, 8'h10); exp_rx(0, 8'h00); exp_rx(1, 8'h00);
    rx_word(8'hA1); rx_word(8'h00); rx_word(8'h10); rx_word(8'h00); rx_word(8'h00);
    spi_cs_n = 1'b1;
    tick(5);
    check("frame1_drained", rx_exp.size(), 0);

    // Word arriving on the cs_n rise cycle is the tail.
    spi_cs_n = 1'b0;
    tick();
    exp_rx(0, 8'h5A); exp_rx(0, 8'h6B); exp_rx(1, 8'h7C);
    rx_word(8'h5A); rx_word(8'h6B);
    spi_rx_valid = 1'b1; spi_rx_data = 8'h7C; spi_cs_n = 1'b1;
    tick();
    spi_rx_valid = 1'b0;
    tick(5);
    check("frame2_drained", rx_exp.size(), 0);

    // RX overflow: 4 fit, the 5th push and the cs-rise tail are dropped.
    m_axis_tready = 1'b0;
    spi_cs_n = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) exp_rx(0, 8'h11 + 8'(i));
    for (int i = 0; i < 6; i++) rx_word(8'h11 + 8'(i));
    spi_cs_n = 1'b1;
    tick(2);
    check("ovf_rx_level", rx_level, 4);
    check("ovf_flag", rx_overflow, 1);
    check("ovf_count_2", ovf_count, 2);
    m_axis_tready = 1'b1;
    tick(6);
    check("ovf_drained", rx_exp.size(), 0);
    status_clr = 1'b1;
    tick();
    status_clr = 1'b0;
    check("clr_ovf_flag", rx_overflow, 0);
    check("clr_ovf_count", ovf_count, 0);

    // Three SPI words loaded one at a time.
    spi_cs_n = 1'b0;
    tick();
    base = tx_seen;
    tx_exp.push_back(8'h55); tx_exp.push_back(8'hAA); tx_exp.push_back(8'h3C);
    tx_word(8'h55); tx_word(8'hAA); tx_word(8'h3C);
    for (int k = 1; k <= 3; k++) begin
      wait_tx(base + k, "tx_load_seen");
      spi_busy = 1'b1;
      tick(16);
      spi_busy = 1'b0;
    end
    tick(4);
    check("tx_three_loads", tx_seen, base + 3);
    check("tx_level_empty", tx_level, 0);
    check("no_underrun_normal", tx_underrun, 0);

    // Underrun: shifter starts with nothing queued.
    spi_busy = 1'b1;
    tick(3);
    spi_busy = 1'b0;
    tick(2);
    check("underrun_set", tx_underrun, 1);
    check("underrun_no_load", tx_seen, base + 3);

    // Clear wins over a same-cycle underrun event.
    status_clr = 1'b1; spi_busy = 1'b1;
    tick();
    status_clr = 1'b0;
    tick(2);
    spi_busy = 1'b0;
    check("clr_priority_underrun", tx_underrun, 0);
    tick(2);

    // Flush on cs_n rise, including a same-cycle push.
    base = tx_seen;
    tx_exp.push_back(8'h01);
    tx_word(8'h01); tx_word(8'h02); tx_word(8'h03); tx_word(8'h04);
    tick(3);
    check("flush_pre_level", tx_level, 3);
    check("flush_pre_loads", tx_seen, base + 1);
    spi_cs_n = 1'b1; s_axis_tvalid = 1'b1; s_axis_tdata = 8'hEE;
    tick();
    s_axis_tvalid = 1'b0;
    check("flush_level", tx_level, 0);
    spi_cs_n = 1'b0;
    tx_exp.push_back(8'h99);
    tx_word(8'h99);
    wait_tx(base + 2, "load_after_flush");
    spi_cs_n = 1'b1;
    tick(2);

    // ovf_count saturation, then clear beating a same-cycle drop.
    m_axis_tready = 1'b0;
    for (int i = 0; i < 4; i++) exp_rx(0, 8'h80 + 8'(i));
    for (int i = 0; i < 5; i++) rx_word(8'h80 + 8'(i));
    spi_rx_valid = 1'b1;
    tick(260);
    spi_rx_valid = 1'b0;
    tick();
    check("sat_ovf_count", ovf_count, 255);
    check("sat_rx_level", rx_level, 4);
    spi_rx_valid = 1'b1; status_clr = 1'b1;
    tick();
    spi_rx_valid = 1'b0; status_clr = 1'b0;
    check("clr_priority_ovf_count", ovf_count, 0);
    check("clr_priority_ovf_flag", rx_overflow, 0);
    m_axis_tready = 1'b1;
    tick(6);
    m_axis_tready = 1'b0;

    check("rx_sb_empty", rx_exp.size(), 0);
    check("tx_sb_empty", tx_exp.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
